register_file_mp: RTL and testbench

//  Parametrised multi-read-port register file; next generation of the 8x16 CPU register file.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_read_port.sv | 62 ++++++
 rtl/register_file_mp.sv | 111 +++++++++++
 tb/tb_register_file_mp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and elaboration helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int rf_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Low bit of element idx inside a packed vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: range-checked address mux, zero-entry and bypass handling,
// and an optional output register with its valid flag.
module regfile_read_port #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int READ_LAT = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem [DEPTH],
    input  logic              wr_accept,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic              in_range;
    logic              is_zero;
    logic              bypass_hit;
    logic [DATA_W-1:0] rd_word_p0;
    logic [DATA_W-1:0] rd_data_p1;
    logic              vld_p1;

    // Stage p0: combinational lookup
    always_comb begin
        in_range   = ({1'b0, rd_addr} < DEPTH_W);
        is_zero    = (ZERO_R0 != 0) && (rd_addr == '0);
        // wr_accept already excludes out-of-range and zero-entry writes
        bypass_hit = (BYPASS != 0) && wr_accept && (wr_addr == rd_addr);
        rd_word_p0 = '0;
        if (in_range && !is_zero) begin
            if (bypass_hit)
                rd_word_p0 = wr_data;
            else
                rd_word_p0 = mem[rd_addr];
        end
    end

    // Stage p1: registered read, data held while rd_en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en)
                rd_data_p1 <= rd_word_p0;
        end
    end

    assign rd_data  = (READ_LAT != 0) ? rd_data_p1 : rd_word_p0;
    assign rd_valid = (READ_LAT != 0) ? vld_p1 : 1'b1;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-read-port register file with write bypass, optional
// hardwired-zero entry and a sequenced bulk clear.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 3,
    parameter int READ_LAT = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [NUM_RD-1:0]        Rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] Rd_addr,
    output logic [NUM_RD*DATA_W-1:0] Rd_data,
    output logic [NUM_RD-1:0]        Rd_valid,
    input  logic                     Wr_en,
    input  logic [ADDR_W-1:0]        Wr_addr,
    input  logic [DATA_W-1:0]        Wr_data,
    output logic                     Wr_ready,
    input  logic                     Clr_req,
    output logic                     Clr_busy,
    output logic                     Clr_done
);

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    clr_state_t        state_q;
    clr_state_t        state_d;
    logic [ADDR_W-1:0] clr_idx_q;
    logic              wr_accept;

    assign wr_accept = Wr_en && Wr_ready
                       && ({1'b0, Wr_addr} < DEPTH_W)
                       && !((ZERO_R0 != 0) && (Wr_addr == '0));

    // Storage: clear sequence owns the array while busy, so no write can collide
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (state_q == CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (wr_accept) begin
            mem[Wr_addr] <= Wr_data;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Clr_req) state_d = CLEAR;
            CLEAR:   if (clr_idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Wr_ready = (state_q == IDLE);
        Clr_busy = (state_q == CLEAR);
        Clr_done = (state_q == CLEAR) && (clr_idx_q == LAST_IDX);
    end

    // Index is parked at 0 in IDLE so every clear starts from entry 0
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            clr_idx_q <= '0;
        else if (state_q == CLEAR && clr_idx_q != LAST_IDX)
            clr_idx_q <= clr_idx_q + 1'b1;
        else
            clr_idx_q <= '0;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        localparam int AO = slice_lo(p, ADDR_W);
        localparam int DO = slice_lo(p, DATA_W);

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .READ_LAT (READ_LAT),
            .BYPASS   (BYPASS),
            .ZERO_R0  (ZERO_R0)
        ) u_port (
            .clk       (CLK),
            .rst_n     (Reset),
            .rd_en     (Rd_en[p]),
            .rd_addr   (Rd_addr[AO +: ADDR_W]),
            .mem       (mem),
            .wr_accept (wr_accept),
            .wr_addr   (Wr_addr),
            .wr_data   (Wr_data),
            .rd_data   (Rd_data[DO +: DATA_W]),
            .rd_valid  (Rd_valid[p])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: default instance (comb read, bypass) and a variant
// (DEPTH=6, registered read, no bypass, hardwired-zero entry 0).
module tb_register_file_mp;

    logic clk;
    logic rst_n;

    logic [2:0]  a_rd_en, b_rd_en;
    logic [8:0]  a_rd_addr, b_rd_addr;
    logic [47:0] a_rd_data, b_rd_data;
    logic [2:0]  a_rd_valid, b_rd_valid;
    logic        a_wr_en, b_wr_en;
    logic [2:0]  a_wr_addr, b_wr_addr;
    logic [15:0] a_wr_data, b_wr_data;
    logic        a_wr_ready, b_wr_ready;
    logic        a_clr_req, b_clr_req;
    logic        a_clr_busy, b_clr_busy;
    logic        a_clr_done, b_clr_done;

    int n_checks = 0;
    int n_pass   = 0;

    register_file_mp u_a (
        .CLK(clk), .Reset(rst_n),
        .Rd_en(a_rd_en), .Rd_addr(a_rd_addr), .Rd_data(a_rd_data), .Rd_valid(a_rd_valid),
        .Wr_en(a_wr_en), .Wr_addr(a_wr_addr), .Wr_data(a_wr_data), .Wr_ready(a_wr_ready),
        .Clr_req(a_clr_req), .Clr_busy(a_clr_busy), .Clr_done(a_clr_done)
    );

    register_file_mp #(
        .DEPTH(6), .READ_LAT(1), .BYPASS(0), .ZERO_R0(1)
    ) u_b (
        .CLK(clk), .Reset(rst_n),
        .Rd_en(b_rd_en), .Rd_addr(b_rd_addr), .Rd_data(b_rd_data), .Rd_valid(b_rd_valid),
        .Wr_en(b_wr_en), .Wr_addr(b_wr_addr), .Wr_data(b_wr_data), .Wr_ready(b_wr_ready),
        .Clr_req(b_clr_req), .Clr_busy(b_clr_busy), .Clr_done(b_clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] a_port(input int p);
        return a_rd_data[p*16 +: 16];
    endfunction

    function automatic logic [15:0] b_port(input int p);
        return b_rd_data[p*16 +: 16];
    endfunction

    task automatic a_write(input logic [2:0] addr, input logic [15:0] data);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic b_write(input logic [2:0] addr, input logic [15:0] data);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data;
        tick();
        b_wr_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_rd_en = '0; a_rd_addr = '0; a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0; a_clr_req = 0;
        b_rd_en = '0; b_rd_addr = '0; b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_clr_req = 0;
        repeat (2) tick();
        rst_n = 1'b1;

        // 1. preload, then async reset clears everything
        a_write(3'd3, 16'hAAAA);
        a_write(3'd5, 16'h5555);
        b_write(3'd1, 16'h1111);
        b_rd_en = 3'b001; b_rd_addr = {3'd0, 3'd0, 3'd1};
        tick();
        chk("pre_b_data", b_port(0), 16'h1111);
        a_rd_addr = {3'd0, 3'd5, 3'd3};
        #1 chk("pre_a_data", a_port(0), 16'hAAAA);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_a_p0", a_port(0), 16'h0);
        chk("rst_a_p1", a_port(1), 16'h0);
        chk("rst_busy", a_clr_busy, 1'b0);
        chk("rst_done", a_clr_done, 1'b0);
        chk("rst_b_data", b_port(0), 16'h0);
        chk("rst_b_valid", b_rd_valid, 3'b000);
        b_rd_en = '0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_a_ready", a_wr_ready, 1'b1);
        chk("rel_b_ready", b_wr_ready, 1'b1);
        chk("rel_a_valid", a_rd_valid, 3'b111);

        // 2. write then read on all ports
        a_write(3'd5, 16'hBEEF);
        a_rd_addr = {3'd5, 3'd5, 3'd5};
        #1;
        for (int p = 0; p < 3; p++) chk($sformatf("a_rd5_p%0d", p), a_port(p), 16'hBEEF);
        b_write(3'd5, 16'hBEEF);
        b_rd_en = 3'b111; b_rd_addr = {3'd5, 3'd5, 3'd5};
        #1 chk("b_valid_before", b_rd_valid, 3'b000);
        tick();
        for (int p = 0; p < 3; p++) chk($sformatf("b_rd5_p%0d", p), b_port(p), 16'hBEEF);
        chk("b_valid_after", b_rd_valid, 3'b111);
        b_rd_en = '0;
        tick();
        chk("b_valid_drop", b_rd_valid, 3'b000);
        chk("b_data_hold", b_port(0), 16'hBEEF);

        // 3. same-cycle write/read on entry 2
        a_write(3'd2, 16'hBEEF);
        a_wr_en = 1'b1; a_wr_addr = 3'd2; a_wr_data = 16'h1234;
        a_rd_addr = {3'd0, 3'd5, 3'd2};
        #1;
        chk("a_bypass", a_port(0), 16'h1234);
        chk("a_nobypass_other", a_port(1), 16'hBEEF);
        tick();
        a_wr_en = 1'b0;
        chk("a_after_write", a_port(0), 16'h1234);
        b_write(3'd2, 16'hBEEF);
        b_wr_en = 1'b1; b_wr_addr = 3'd2; b_wr_data = 16'h1234;
        b_rd_en = 3'b001; b_rd_addr = {3'd0, 3'd0, 3'd2};
        tick();
        b_wr_en = 1'b0;
        chk("b_no_bypass", b_port(0), 16'hBEEF);
        tick();
        chk("b_after_write", b_port(0), 16'h1234);

        // 4. zero entry and address range
        b_write(3'd0, 16'hFFFF);
        b_rd_addr = {3'd0, 3'd0, 3'd0};
        tick();
        chk("b_zero_r0", b_port(0), 16'h0);
        b_rd_addr = {3'd0, 3'd0, 3'd7};
        tick();
        chk("b_oor_read", b_port(0), 16'h0);
        b_write(3'd6, 16'h5A5A);
        b_rd_addr = {3'd0, 3'd5, 3'd6};
        b_rd_en = 3'b011;
        tick();
        chk("b_oor_write", b_port(0), 16'h0);
        chk("b_entry5_kept", b_port(1), 16'hBEEF);
        b_rd_en = '0;
        a_write(3'd0, 16'hFFFF);
        a_rd_addr = {3'd0, 3'd0, 3'd0};
        #1 chk("a_entry0_normal", a_port(0), 16'hFFFF);

        // 5. fill and bulk clear
        for (int i = 0; i < 7; i++) a_write(3'(i), 16'h1000 + 16'(i));
        a_clr_req = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 3'd7; a_wr_data = 16'h7777;
        #1 chk("clr_req_busy", a_clr_busy, 1'b0);
        tick();
        a_clr_req = 1'b0; a_wr_en = 1'b0;
        a_rd_addr = {3'd7, 3'd1, 3'd0};
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) begin
                a_wr_en = 1'b1; a_wr_addr = 3'd1; a_wr_data = 16'hDEAD;
            end
            #1;
            chk($sformatf("clr%0d_busy", c), a_clr_busy, 1'b1);
            chk($sformatf("clr%0d_ready", c), a_wr_ready, 1'b0);
            chk($sformatf("clr%0d_done", c), a_clr_done, (c == 8));
            chk($sformatf("clr%0d_e0", c), a_port(0), (c == 1) ? 16'h1000 : 16'h0);
            chk($sformatf("clr%0d_e1", c), a_port(1), (c <= 2) ? 16'h1001 : 16'h0);
            chk($sformatf("clr%0d_e7", c), a_port(2), 16'h7777);
            tick();
            a_wr_en = 1'b0;
        end
        chk("clr_end_busy", a_clr_busy, 1'b0);
        chk("clr_end_ready", a_wr_ready, 1'b1);
        chk("clr_end_done", a_clr_done, 1'b0);
        for (int e = 0; e < 8; e++) begin
            a_rd_addr = {3'd0, 3'd0, 3'(e)};
            #1 chk($sformatf("clr_entry%0d", e), a_port(0), 16'h0);
        end

        // 6. reset during clear cycle 4
        a_write(3'd5, 16'h5555);
        a_write(3'd6, 16'h6666);
        a_clr_req = 1'b1;
        tick();
        a_clr_req = 1'b0;
        repeat (3) tick();
        #1 chk("abort_busy_pre", a_clr_busy, 1'b1);
        #1 rst_n = 1'b0;
        a_rd_addr = {3'd0, 3'd6, 3'd5};
        #1;
        chk("abort_busy", a_clr_busy, 1'b0);
        chk("abort_done", a_clr_done, 1'b0);
        chk("abort_e5", a_port(0), 16'h0);
        chk("abort_e6", a_port(1), 16'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("post_abort%0d_done", c), a_clr_done, 1'b0);
            chk($sformatf("post_abort%0d_busy", c), a_clr_busy, 1'b0);
            tick();
        end
        chk("post_abort_ready", a_wr_ready, 1'b1);
        a_write(3'd3, 16'h4321);
        a_rd_addr = {3'd0, 3'd0, 3'd3};
        #1 chk("post_abort_write", a_port(0), 16'h4321);

        // DEPTH=6 clear with request held through the done cycle
        b_write(3'd5, 16'h5050);
        b_clr_req = 1'b1;
        #1 chk("b_clr_idle", b_clr_busy, 1'b0);
        tick();
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk($sformatf("b_clr%0d_busy", c), b_clr_busy, 1'b1);
            chk($sformatf("b_clr%0d_done", c), b_clr_done, (c == 6));
            tick();
        end
        chk("b_gap_idle", b_clr_busy, 1'b0);
        tick();
        chk("b_restart", b_clr_busy, 1'b1);
        b_clr_req = 1'b0;
        repeat (6) tick();
        chk("b_restart_end", b_clr_busy, 1'b0);
        b_rd_en = 3'b001; b_rd_addr = {3'd0, 3'd0, 3'd5};
        tick();
        chk("b_cleared_e5", b_port(0), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
